// File: rtl/decoder_nx2n_scan_pkg.sv
// Shared definitions for the decoder_nx2n_scan block: mode encodings and a
// ceiling-log2 helper used to size the optional dwell counter (DECO_DWELL_EN).
package decoder_nx2n_scan_pkg;

    localparam logic MODE_DIRECT = 1'b0;
    localparam logic MODE_SCAN   = 1'b1;

    // Ceiling log2; clog2(1) = 0, clog2(2) = 1, clog2(4) = 2, clog2(5) = 3.
    function automatic int unsigned clog2(input int unsigned v);
        int unsigned r;
        r = 0;
        while ((64'd1 << r) < 64'(v)) begin
            r = r + 1;
        end
        return r;
    endfunction

endpackage

// File: rtl/decoder_nx2n_scan_counter.sv
// Scan index sequencer for decoder_nx2n_scan.
// index_o is the index to be shown for the current cycle (the load value on a
// load cycle, else the held index). With macro DECO_DWELL_EN defined each index
// is shown for Dwell enabled cycles; otherwise the index advances every enabled
// cycle. wrap_pulse_o flags the first enabled cycle that shows index 0 after an
// advance from the top index.
module deco_scan_counter
    import decoder_nx2n_scan_pkg::*;
#(
    parameter int unsigned N     = 2,
    parameter int unsigned Dwell = 4
) (
    input  logic         clk_i,
    input  logic         rst_i,
    input  logic         en_i,
    input  logic         load_i,
    input  logic [N-1:0] load_val_i,
    output logic [N-1:0] index_o,
    output logic         wrap_pulse_o
);

    if (N < 1 || Dwell < 1) begin : g_bad_param
        $error("deco_scan_counter: N and Dwell must both be at least 1");
    end

    localparam logic [N-1:0] IdxMax = {N{1'b1}};

    logic [N-1:0] idx_q, idx_d;
    logic [N-1:0] cur_idx;
    logic         pend_q, pend_d;
    logic         advance;

`ifdef DECO_DWELL_EN
    localparam int unsigned CntW = clog2(Dwell + 1);

    logic [CntW-1:0] cnt_q, cnt_d;
    logic [CntW-1:0] cur_cnt;

    // Dwell count: a load restarts the dwell of the loaded index.
    always_comb begin
        cur_cnt = load_i ? '0 : cnt_q;
        advance = 1'b0;
        cnt_d   = cnt_q;
        if (en_i) begin
            if (cur_cnt == CntW'(Dwell - 1)) begin
                advance = 1'b1;
                cnt_d   = '0;
            end else begin
                cnt_d   = cur_cnt + CntW'(1);
            end
        end
    end

    // Dwell count register; holds while disabled.
    always_ff @(posedge clk_i) begin
        if (rst_i) begin
            cnt_q <= '0;
        end else begin
            cnt_q <= cnt_d;
        end
    end
`else
    // Without a dwell counter every enabled scan cycle advances.
    always_comb begin
        advance = en_i;
    end
`endif

    // Index select, advance modulo 2**N, and pending-wrap flag.
    always_comb begin
        cur_idx = load_i ? load_val_i : idx_q;
        idx_d   = idx_q;
        pend_d  = pend_q;
        if (en_i) begin
            idx_d  = advance ? cur_idx + N'(1) : cur_idx;
            // Index 0 is shown on the next enabled cycle after this advance.
            pend_d = advance && (cur_idx == IdxMax);
        end
        index_o      = cur_idx;
        wrap_pulse_o = en_i && !load_i && pend_q;
    end

    // Index and wrap flag registers; both freeze while disabled.
    always_ff @(posedge clk_i) begin
        if (rst_i) begin
            idx_q  <= '0;
            pend_q <= 1'b0;
        end else begin
            idx_q  <= idx_d;
            pend_q <= pend_d;
        end
    end

endmodule

// File: rtl/decoder_nx2n_scan.sv
// Registered N-to-2**N one-cold decoder with active-low enable.
// DIRECT mode decodes addr; SCAN mode walks every output in turn, starting from
// addr on a DIRECT->SCAN edge. Macro DECO_DWELL_EN holds each scan index for
// DWELL cycles; undefined, the index advances every enabled scan cycle.
module decoder_nx2n_scan
    import decoder_nx2n_scan_pkg::*;
#(
    parameter int unsigned N     = 2,
    parameter int unsigned DWELL = 4
) (
    input  logic              clock,
    input  logic              reset,
    input  logic              enable_n,
    input  logic              mode,
    input  logic [N-1:0]      addr,
    output logic [2**N-1:0]   D,
    output logic [N-1:0]      sel,
    output logic              active,
    output logic              wrap
);

    localparam int unsigned Lines = 2**N;

    logic             mode_q;
    logic             mode_edge;
    logic             scan_en;
    logic [N-1:0]     scan_idx;
    logic             scan_wrap;

    logic [Lines-1:0] d_q, d_d;
    logic [N-1:0]     sel_q, sel_d;
    logic             active_q, active_d;
    logic             wrap_q, wrap_d;
    logic [N-1:0]     pick;

    // Scan control: the edge is judged against the mode seen last cycle.
    always_comb begin
        scan_en   = (mode == MODE_SCAN) && !enable_n;
        mode_edge = scan_en && (mode_q == MODE_DIRECT);
    end

    deco_scan_counter #(
        .N     (N),
        .Dwell (DWELL)
    ) u_scan_counter (
        .clk_i        (clock),
        .rst_i        (reset),
        .en_i         (scan_en),
        .load_i       (mode_edge),
        .load_val_i   (addr),
        .index_o      (scan_idx),
        .wrap_pulse_o (scan_wrap)
    );

    // Next-state of the output registers: one-cold decode of the chosen index.
    always_comb begin
        d_d      = '1;
        sel_d    = sel_q;
        active_d = 1'b0;
        wrap_d   = 1'b0;
        pick     = (mode == MODE_SCAN) ? scan_idx : addr;
        if (!enable_n) begin
            d_d[pick] = 1'b0;
            sel_d     = pick;
            active_d  = 1'b1;
            wrap_d    = (mode == MODE_SCAN) && scan_wrap;
        end
    end

    // Output registers; mode history tracks through reset so that a SCAN mode
    // held across reset starts at index 0 rather than reloading addr.
    always_ff @(posedge clock) begin
        mode_q <= mode;
        if (reset) begin
            d_q      <= '1;
            sel_q    <= '0;
            active_q <= 1'b0;
            wrap_q   <= 1'b0;
        end else begin
            d_q      <= d_d;
            sel_q    <= sel_d;
            active_q <= active_d;
            wrap_q   <= wrap_d;
        end
    end

    assign D      = d_q;
    assign sel    = sel_q;
    assign active = active_q;
    assign wrap   = wrap_q;

endmodule

// File: tb/tb_decoder_nx2n_scan.sv
// Directed self-checking bench for decoder_nx2n_scan (N=2, DWELL=3).
// Scan and freeze expectations follow DECO_DWELL_EN when it is defined.
module tb_decoder_nx2n_scan;

    localparam int unsigned N     = 2;
    localparam int unsigned DWELL = 3;

    logic         clock;
    logic         reset;
    logic         enable_n;
    logic         mode;
    logic [N-1:0] addr;
    logic [3:0]   D;
    logic [N-1:0] sel;
    logic         active;
    logic         wrap;

    int checks = 0;
    int errors = 0;
    bit sb_on  = 1'b0;

    decoder_nx2n_scan #(
        .N     (N),
        .DWELL (DWELL)
    ) dut (
        .clock    (clock),
        .reset    (reset),
        .enable_n (enable_n),
        .mode     (mode),
        .addr     (addr),
        .D        (D),
        .sel      (sel),
        .active   (active),
        .wrap     (wrap)
    );

    initial clock = 1'b0;
    always #5 clock = ~clock;

    function automatic logic [3:0] onecold(input int i);
        logic [3:0] v;
        v = 4'b1111;
        v[i] = 1'b0;
        return v;
    endfunction

    task automatic step();
        @(posedge clock);
        #1;
    endtask

    // One-cold invariant on every cycle.
    always @(negedge clock) begin
        if (sb_on) begin
            checks++;
            if ($countones(~D) > 1 || active !== ~&D) begin
                errors++;
                $display("FAIL invariant: D=%b active=%b at %0t", D, active, $time);
            end
        end
    end

    task automatic test_reset();
        reset = 1'b1; mode = 1'b1; enable_n = 1'b0; addr = 2'd2;
        step();
        sb_on = 1'b1;
        step();
        checks++;
        if (D !== 4'b1111 || sel !== 2'd0 || active !== 1'b0 || wrap !== 1'b0) begin
            errors++;
            $display("FAIL reset_state: D=%b sel=%0d active=%b wrap=%b, want 1111 0 0 0",
                     D, sel, active, wrap);
        end
        reset = 1'b0;
        step();
        checks++;
        if (D !== 4'b1110 || sel !== 2'd0 || active !== 1'b1 || wrap !== 1'b0) begin
            errors++;
            $display("FAIL reset_release_scan0: D=%b sel=%0d active=%b wrap=%b, want 1110 0 1 0",
                     D, sel, active, wrap);
        end
    endtask

    task automatic test_direct();
        logic [3:0] exp_d [4];
        exp_d = '{4'b1110, 4'b1101, 4'b1011, 4'b0111};
        mode = 1'b0; enable_n = 1'b0;
        for (int i = 0; i < 4; i++) begin
            addr = 2'(i);
            step();
            checks++;
            if (D !== exp_d[i] || sel !== 2'(i) || active !== 1'b1 || wrap !== 1'b0) begin
                errors++;
                $display("FAIL direct[%0d]: D=%b sel=%0d active=%b wrap=%b, want %b %0d 1 0",
                         i, D, sel, active, wrap, exp_d[i], i);
            end
        end
    endtask

`ifdef DECO_DWELL_EN
    task automatic test_scan();
        int exp_idx [9];
        bit exp_wrap [9];
        exp_idx  = '{3, 3, 3, 0, 0, 0, 1, 1, 1};
        exp_wrap = '{0, 0, 0, 1, 0, 0, 0, 0, 0};
        mode = 1'b0; enable_n = 1'b0; addr = 2'd0;
        step();
        mode = 1'b1; addr = 2'd3;
        for (int i = 0; i < 9; i++) begin
            step();
            addr = 2'd1;
            checks++;
            if (D !== onecold(exp_idx[i]) || sel !== 2'(exp_idx[i]) || wrap !== exp_wrap[i]) begin
                errors++;
                $display("FAIL scan_dwell[%0d]: D=%b sel=%0d wrap=%b, want %b %0d %b",
                         i, D, sel, wrap, onecold(exp_idx[i]), exp_idx[i], exp_wrap[i]);
            end
        end
    endtask
`else
    task automatic test_scan();
        int exp_idx [5];
        bit exp_wrap [5];
        exp_idx  = '{2, 3, 0, 1, 2};
        exp_wrap = '{0, 0, 1, 0, 0};
        mode = 1'b0; enable_n = 1'b0; addr = 2'd0;
        step();
        mode = 1'b1; addr = 2'd2;
        for (int i = 0; i < 5; i++) begin
            step();
            addr = 2'd0;
            checks++;
            if (D !== onecold(exp_idx[i]) || sel !== 2'(exp_idx[i]) || wrap !== exp_wrap[i]) begin
                errors++;
                $display("FAIL scan[%0d]: D=%b sel=%0d wrap=%b, want %b %0d %b",
                         i, D, sel, wrap, onecold(exp_idx[i]), exp_idx[i], exp_wrap[i]);
            end
        end
    endtask
`endif

    task automatic test_freeze();
        int exp_idx [3];
`ifdef DECO_DWELL_EN
        exp_idx = '{1, 1, 2};
`else
        exp_idx = '{2, 3, 0};
`endif
        mode = 1'b0; enable_n = 1'b0; addr = 2'd0;
        step();
        mode = 1'b1; addr = 2'd1;
        step();
        checks++;
        if (D !== 4'b1101) begin
            errors++;
            $display("FAIL freeze_load: D=%b, want 1101", D);
        end
        enable_n = 1'b1; addr = 2'd3;
        for (int i = 0; i < 5; i++) begin
            step();
            checks++;
            if (D !== 4'b1111 || active !== 1'b0 || wrap !== 1'b0) begin
                errors++;
                $display("FAIL freeze_hold[%0d]: D=%b active=%b wrap=%b, want 1111 0 0",
                         i, D, active, wrap);
            end
        end
        enable_n = 1'b0;
        for (int i = 0; i < 3; i++) begin
            step();
            checks++;
            if (D !== onecold(exp_idx[i]) || active !== 1'b1) begin
                errors++;
                $display("FAIL freeze_resume[%0d]: D=%b active=%b, want %b 1",
                         i, D, active, onecold(exp_idx[i]));
            end
        end
    endtask

    task automatic test_reset_mid_scan();
        mode = 1'b0; enable_n = 1'b0; addr = 2'd0;
        step();
        mode = 1'b1; addr = 2'd3;
        step();
        checks++;
        if (D !== 4'b0111 || sel !== 2'd3) begin
            errors++;
            $display("FAIL midscan_at3: D=%b sel=%0d, want 0111 3", D, sel);
        end
        reset = 1'b1;
        step();
        checks++;
        if (D !== 4'b1111 || active !== 1'b0 || sel !== 2'd0) begin
            errors++;
            $display("FAIL midscan_reset: D=%b active=%b sel=%0d, want 1111 0 0", D, active, sel);
        end
        reset = 1'b0;
        step();
        checks++;
        if (D !== 4'b1110 || sel !== 2'd0 || wrap !== 1'b0) begin
            errors++;
            $display("FAIL midscan_restart: D=%b sel=%0d wrap=%b, want 1110 0 0", D, sel, wrap);
        end
        mode = 1'b0; addr = 2'd1;
        step();
        checks++;
        if (D !== 4'b1101 || sel !== 2'd1 || wrap !== 1'b0) begin
            errors++;
            $display("FAIL scan_to_direct: D=%b sel=%0d wrap=%b, want 1101 1 0", D, sel, wrap);
        end
    endtask

    initial begin
        reset = 1'b1; enable_n = 1'b0; mode = 1'b1; addr = '0;
        test_reset();
        test_direct();
        test_scan();
        test_freeze();
        test_reset_mid_scan();
        step();
        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
